// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit framer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_tx_state_t;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;

  // Bit periods in one frame after SYNC: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned stop_bits,
                                            input logic        parity);
    return 32'(1) + data_bits + 32'(parity) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_framer_piso_shift.sv
// Parallel-load, right-shift register feeding the serial data bit (LSB first).
module piso_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_BITS data (LSB first), optional even parity, STOP_BITS stop.
// Even parity bit is present only when UART_TX_PARITY_EN is defined.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_SYNC   = 3'(SYNC);
  localparam logic [2:0] ST_START  = 3'(START);
  localparam logic [2:0] ST_DATA   = 3'(DATA);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'(PARITY);
`endif
  localparam logic [2:0] ST_STOP   = 3'(STOP);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_d, in_ready_d, busy_d;
  logic             load, shift, shift_out;

  piso_shift #(
    .WIDTH (DATA_BITS)
  ) u_shift (
    .clk   (clk),
    .rst   (r),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .sout  (shift_out)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Even parity of the accepted byte, captured alongside the shift register load.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^in_data;
    end
  end
`endif

  // Next-state and next-output logic; tx/in_ready/busy are registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (in_valid && in_ready) begin
          state_d = ST_SYNC;
          load    = 1'b1;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_out;
          shift   = 1'b1;
          cnt_d   = CNT_W'(DATA_BITS - 1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt_q == '0) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
            cnt_d   = CNT_W'(STOP_BITS - 1);
`endif
          end else begin
            tx_d  = shift_out;
            shift = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          cnt_d   = CNT_W'(STOP_BITS - 1);
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx       <= tx_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer against a bit-period level frame model.
module tb_uart_tx_framer;

  localparam int C        = 4;
  localparam int DB       = 8;
  localparam int LOOP_MAX = 200;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       r;
  logic       tick;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, tx, busy;
  logic [7:0] in_data2;
  logic       in_valid2;
  logic       in_ready2, tx2, busy2;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk      (clk),
    .r        (r),
    .tick     (tick),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  // Second instance: two stop bits with tick held high (one bit per clk).
  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .r        (r),
    .tick     (1'b1),
    .in_data  (in_data2),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .tx       (tx2),
    .busy     (busy2)
  );

  // One clock; tick emulates a counter with period C.
  task automatic step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % C;
    tick  = (phase == 0);
  endtask

  // Expected tx after n tick edges past accept (n=0 is SYNC; past the frame is idle).
  function automatic logic exp_tx(input logic [7:0] d, input int stops, input int n);
    int len;
    len = 1 + DB + PAR + stops;
    if (n == 0 || n > len) return 1'b1;
    if (n == 1) return 1'b0;
    if (n <= 1 + DB) return d[n-2];
    if (PAR == 1 && n == 2 + DB) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset();
    r = 1'b1; tick = 1'b0; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
    step(); step();
    checks++;
    if ({tx, in_ready, busy} !== 3'b110) begin
      failures++; $display("FAIL reset got tx=%b rdy=%b busy=%b exp 1 1 0", tx, in_ready, busy);
    end
    checks++;
    if ({tx2, in_ready2, busy2} !== 3'b110) begin
      failures++; $display("FAIL reset2 got tx=%b rdy=%b busy=%b exp 1 1 0", tx2, in_ready2, busy2);
    end
    r = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [7:0] d;
    int n, len;
    logic tk, eb;
    d = 8'hA5; n = 0; len = 1 + DB + PAR + 1;
    in_data = d; in_valid = 1'b1; step(); in_valid = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++; $display("FAIL single_accept got busy=%b rdy=%b exp 1 0", busy, in_ready);
    end
    for (int k = 0; k < LOOP_MAX && n <= len; k++) begin
      tk = tick; step(); if (tk) n++;
      checks++;
      if (tx !== exp_tx(d, 1, n)) begin
        failures++; $display("FAIL single_tx n=%0d got=%b exp=%b", n, tx, exp_tx(d, 1, n));
      end
      eb = (n <= len);
      checks++;
      if ({busy, in_ready} !== {eb, ~eb}) begin
        failures++; $display("FAIL single_hs n=%0d got busy=%b rdy=%b exp busy=%b", n, busy, in_ready, eb);
      end
    end
    checks++;
    if (n <= len) begin failures++; $display("FAIL single_timeout ticks=%0d exp=%0d", n, len + 1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int n, len;
    logic tk, eb;
    len = 1 + DB + PAR + 1;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h00 : 8'hFF;
      if (f == 0) begin
        in_data = d; in_valid = 1'b1; step();
        in_data = 8'hFF;
      end else begin
        step(); in_valid = 1'b0;
      end
      checks++;
      if ({busy, in_ready, tx} !== 3'b101) begin
        failures++; $display("FAIL b2b_accept%0d got busy=%b rdy=%b tx=%b exp 1 0 1", f, busy, in_ready, tx);
      end
      n = 0;
      for (int k = 0; k < LOOP_MAX && n <= len; k++) begin
        tk = tick; step(); if (tk) n++;
        checks++;
        if (tx !== exp_tx(d, 1, n)) begin
          failures++; $display("FAIL b2b_tx%0d n=%0d got=%b exp=%b", f, n, tx, exp_tx(d, 1, n));
        end
        eb = (n <= len);
        checks++;
        if ({busy, in_ready} !== {eb, ~eb}) begin
          failures++; $display("FAIL b2b_hs%0d n=%0d got busy=%b rdy=%b exp busy=%b", f, n, busy, in_ready, eb);
        end
      end
      checks++;
      if (n <= len) begin failures++; $display("FAIL b2b_timeout%0d ticks=%0d", f, n); end
    end
  endtask

  task automatic test_accept_on_tick();
    logic [7:0] d;
    int n, len, first_low;
    logic tk;
    d = 8'($urandom); n = 0; len = 1 + DB + PAR + 1; first_low = -1;
    for (int k = 0; k < 2 * C && !tick; k++) step();
    in_data = d; in_valid = 1'b1;
    checks++;
    if (tick !== 1'b1) begin failures++; $display("FAIL coinc_align got tick=%b exp 1", tick); end
    step(); in_valid = 1'b0;
    for (int k = 0; k < LOOP_MAX && n <= len; k++) begin
      tk = tick; step(); if (tk) n++;
      if (tx === 1'b0 && first_low < 0) first_low = k + 1;
      checks++;
      if (tx !== exp_tx(d, 1, n)) begin
        failures++; $display("FAIL coinc_tx n=%0d got=%b exp=%b", n, tx, exp_tx(d, 1, n));
      end
    end
    checks++;
    if (first_low != C) begin
      failures++; $display("FAIL coinc_start_delay got=%0d clks exp=%0d", first_low, C);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL coinc_end got rdy=%b exp 1", in_ready); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int n, len;
    logic tk, eb;
    d = 8'h3C; n = 0; len = 1 + DB + PAR + 1;
    in_data = d; in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int k = 0; k < LOOP_MAX && n < 5; k++) begin
      tk = tick; step(); if (tk) n++;
      checks++;
      if (tx !== exp_tx(d, 1, n)) begin
        failures++; $display("FAIL rstmid_tx n=%0d got=%b exp=%b", n, tx, exp_tx(d, 1, n));
      end
    end
    #1 r = 1'b1;
    #1;
    checks++;
    if ({tx, in_ready, busy} !== 3'b110) begin
      failures++; $display("FAIL rstmid_async got tx=%b rdy=%b busy=%b exp 1 1 0", tx, in_ready, busy);
    end
    step(); r = 1'b0; step();
    d = 8'h81; n = 0;
    in_data = d; in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int k = 0; k < LOOP_MAX && n <= len; k++) begin
      tk = tick; step(); if (tk) n++;
      checks++;
      if (tx !== exp_tx(d, 1, n)) begin
        failures++; $display("FAIL rstmid_next_tx n=%0d got=%b exp=%b", n, tx, exp_tx(d, 1, n));
      end
      eb = (n <= len);
      checks++;
      if ({busy, in_ready} !== {eb, ~eb}) begin
        failures++; $display("FAIL rstmid_next_hs n=%0d got busy=%b exp=%b", n, busy, eb);
      end
    end
    checks++;
    if (n <= len) begin failures++; $display("FAIL rstmid_timeout ticks=%0d", n); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int n, len;
    logic tk, eb;
    len = 1 + DB + PAR + 1;
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 6)) step();
      d = 8'($urandom); n = 0;
      in_data = d; in_valid = 1'b1; step(); in_valid = 1'b0;
      for (int k = 0; k < LOOP_MAX && n <= len; k++) begin
        in_data = 8'($urandom);
        tk = tick; step(); if (tk) n++;
        checks++;
        if (tx !== exp_tx(d, 1, n)) begin
          failures++; $display("FAIL rand_tx d=%h n=%0d got=%b exp=%b", d, n, tx, exp_tx(d, 1, n));
        end
        eb = (n <= len);
        checks++;
        if ({busy, in_ready} !== {eb, ~eb}) begin
          failures++; $display("FAIL rand_hs d=%h n=%0d got busy=%b exp=%b", d, n, busy, eb);
        end
      end
      checks++;
      if (n <= len) begin failures++; $display("FAIL rand_timeout d=%h ticks=%0d", d, n); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    logic       pexp, pbit;
    int n, len;
    logic tk;
    len = 1 + DB + 1 + 1;
    for (int f = 0; f < 2; f++) begin
      d    = (f == 0) ? 8'hA5 : 8'h07;
      pexp = (f == 0) ? 1'b0 : 1'b1;
      pbit = 1'bx; n = 0;
      in_data = d; in_valid = 1'b1; step(); in_valid = 1'b0;
      for (int k = 0; k < LOOP_MAX && n <= len; k++) begin
        tk = tick; step(); if (tk) n++;
        if (tk && n == 2 + DB) pbit = tx;
        checks++;
        if (tx !== exp_tx(d, 1, n)) begin
          failures++; $display("FAIL par_tx d=%h n=%0d got=%b exp=%b", d, n, tx, exp_tx(d, 1, n));
        end
      end
      checks++;
      if (pbit !== pexp) begin failures++; $display("FAIL par_bit d=%h got=%b exp=%b", d, pbit, pexp); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL par_len d=%h got busy=%b exp 0", d, busy); end
    end
  endtask
`endif

  task automatic test_stop2_cont();
    logic [7:0] d;
    int n, busy_clks;
    d = 8'h5A; n = 0;
    in_data2 = d; in_valid2 = 1'b1; step(); in_valid2 = 1'b0;
    busy_clks = busy2 ? 1 : 0;
    for (int k = 0; k < LOOP_MAX && busy2; k++) begin
      step(); n++;
      if (busy2) busy_clks++;
      checks++;
      if (tx2 !== exp_tx(d, 2, n)) begin
        failures++; $display("FAIL stop2_tx n=%0d got=%b exp=%b", n, tx2, exp_tx(d, 2, n));
      end
    end
    checks++;
    if (busy_clks != 12 + PAR) begin
      failures++; $display("FAIL stop2_busy_clks got=%0d exp=%0d", busy_clks, 12 + PAR);
    end
    checks++;
    if (in_ready2 !== 1'b1) begin failures++; $display("FAIL stop2_end got rdy=%b exp 1", in_ready2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_accept_on_tick();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_stop2_cont();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Serial transmit framer downstream of the tick counter: consumes its single-cycle `tick` strobe (one pulse every C clocks) as the bit-period enable.
- Accepts parallel bytes over a valid/ready handshake and shifts out an asynchronous serial frame LSB first: start bit, data bits, optional parity, stop bit(s).
- Sits between the system-side producer and the `tx` pad.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits per frame; legal 1..2.

Ports:
- clk  input  1  system clock, rising-edge.
- r  input  1  reset, asynchronous, active-high.
- tick  input  1  bit-period strobe from the tick counter; high exactly one clk per bit period.
- in_data  input  DATA_BITS  byte to send; sampled on accept.
- in_valid  input  1  producer has in_data.
- in_ready  output  1  framer can accept; high only in IDLE.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high from accept until return to IDLE.

Behaviour:
- Reset values: tx=1, in_ready=1, busy=0, state=IDLE, shift register=0, bit counter=0. Reset is asynchronous, so a reset mid-frame forces tx=1 immediately and drops the frame.
- Accept: in_valid && in_ready at a clk edge latches in_data, goes to SYNC, and sets busy=1, in_ready=0 for the next cycle. There is no combinational path from in_valid to in_ready.
- States and transitions:
  - IDLE -> SYNC on accept.
  - SYNC -> START on the next tick; tx=0 from that edge.
  - START -> DATA on tick.
  - DATA stays DATA for DATA_BITS ticks total, driving shift[0] then shifting right.
  - DATA -> PARITY on tick if the feature is enabled, else -> STOP.
  - PARITY -> STOP on tick.
  - STOP counts STOP_BITS ticks at tx=1, then -> IDLE.
- Timing: each bit occupies exactly one tick period, tick edge to tick edge. Frame length is (1 + DATA_BITS + [1] + STOP_BITS) tick periods after SYNC.
- tick in IDLE is ignored. tick in the same cycle as accept is ignored; SYNC waits for the next tick.
- Return to IDLE: in_ready=1 and busy=0 the cycle after the final stop tick. A back-to-back accept in that cycle gives a gapless frame, because its SYNC lasts one full tick period during which tx stays 1 as extra stop time.
- in_data changing while busy has no effect.
- Bit counter width is $clog2(DATA_BITS+1) and wraps only through reload on state entry.
- tick held high continuously is legal: one bit per clk (test mode).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA. tx = XOR of the latched data, i.e. even parity; the XOR is computed at accept and registered.
- Undefined: no PARITY state and no parity register; the DATA -> STOP transition goes direct.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, SYNC, START, DATA, PARITY, STOP}.
  - Localparams for legal DATA_BITS / STOP_BITS ranges.
  - Function frame_len(DATA_BITS, STOP_BITS, parity).
- One natural sub-module: piso_shift (parallel-load, right-shift register with load/shift enables). The FSM and counters stay in uart_tx_framer.

Test Plan:
- Setup for all scenarios: tick from counter C=4, DATA_BITS=8, STOP_BITS=1, parity off.
- Single byte: send 0xA5 -> tx per tick period = 0,1,0,1,0,0,1,0,1,1; busy high 11 tick periods including SYNC; in_ready back high one cycle after the stop tick.
- Back-to-back: send 0x00 then 0xFF with in_valid held -> second accepted the cycle in_ready rises; tx = 0,00000000,1,(1 SYNC),0,11111111,1; no glitch low between frames.
- Accept coincident with tick: in_valid and tick both high in IDLE -> start bit begins on the following tick (4 clks later), not on the coincident edge.
- Reset mid-frame: assert r during data bit 3 of 0x3C -> tx=1 asynchronously in the same cycle; in_ready=1, busy=0; next byte 0x81 framed correctly.
- Parity build (UART_TX_PARITY_EN): send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; frame is 11 bit periods.
- STOP_BITS=2, continuous tick: send 0x5A -> 12 clks busy-to-idle, tx ends with 1,1.
